// File: rtl/hcsr04_echo_timer.sv
// HC-SR04 echo timer: fires the trigger pulse, times the synchronised echo
// in clk cycles and publishes a held width with a single-cycle valid strobe.
// A missing echo or an echo longer than the sensor's no-object width both
// report ECHO_MAX_TICKS with timeout set, so downstream sees "far".
module hcsr04_echo_timer #(
  parameter logic [31:0] TRIG_TICKS          = 32'd120,
  parameter logic [31:0] START_TIMEOUT_TICKS = 32'd24_000,
  parameter logic [31:0] ECHO_MAX_TICKS      = 32'd456_000,
  parameter logic [31:0] COOLDOWN_TICKS      = 32'd720_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        echo,
  output logic        trig,
  output logic [31:0] echo_width,
  output logic        width_valid,
  output logic        timeout
);

  typedef enum logic [2:0] {
    S_TRIG_PENDING = 3'd0,
    S_TRIG         = 3'd1,
    S_WAIT_RISE    = 3'd2,
    S_MEASURE      = 3'd3,
    S_WAIT_LOW     = 3'd4,
    S_COOLDOWN     = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Echo synchroniser and edge detect
  logic echo_meta_q;
  logic echo_s_q;
  logic echo_s_prev_q;
  logic rise_q;
  logic rise_d;
  logic echo_lvl;

  // Shared counter: trigger length, start wait, echo width, cooldown
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;

  // Registered outputs
  logic        trig_q, trig_d;
  logic [31:0] width_q, width_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;

  // Per-state terminal conditions
  logic trig_done;
  logic start_expired;
  logic echo_full;
  logic cool_done;

  // A rise is echo_s high now and low the cycle before; it is registered, so
  // the level that lines up with it is the one-cycle-delayed echo_s.  Using
  // that delayed level while measuring gives both edges the same latency.
  assign rise_d   = echo_s_q & ~echo_s_prev_q;
  assign echo_lvl = echo_s_prev_q;

  // The counter never wraps: it sticks at all-ones if ever driven that far.
  assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

  assign trig_done     = (cnt_inc >= TRIG_TICKS);
  assign start_expired = (cnt_inc >= START_TIMEOUT_TICKS);
  assign echo_full     = (cnt_inc >= ECHO_MAX_TICKS);
  assign cool_done     = (cnt_inc >= COOLDOWN_TICKS);

  // State register, synchroniser and output flops with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_TRIG_PENDING;
      echo_meta_q   <= 1'b0;
      echo_s_q      <= 1'b0;
      echo_s_prev_q <= 1'b0;
      rise_q        <= 1'b0;
      cnt_q         <= 32'd0;
      trig_q        <= 1'b0;
      width_q       <= 32'd0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      echo_meta_q   <= echo;
      echo_s_q      <= echo_meta_q;
      echo_s_prev_q <= echo_s_q;
      rise_q        <= rise_d;
      cnt_q         <= cnt_d;
      trig_q        <= trig_d;
      width_q       <= width_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
    end
  end

  // Next-state logic; a rise in S_WAIT_RISE wins over a same-cycle timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TRIG_PENDING: state_d = S_TRIG;
      S_TRIG: begin
        if (trig_done) begin
          state_d = S_WAIT_RISE;
        end
      end
      S_WAIT_RISE: begin
        if (rise_q) begin
          state_d = S_MEASURE;
        end else if (start_expired) begin
          state_d = S_COOLDOWN;
        end
      end
      S_MEASURE: begin
        if (!echo_lvl) begin
          state_d = S_COOLDOWN;
        end else if (echo_full) begin
          state_d = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!echo_lvl) begin
          state_d = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        if (cool_done) begin
          state_d = S_TRIG;
        end
      end
      default: state_d = S_TRIG_PENDING;
    endcase
  end

  // Counter and output values for the next cycle; results only move on a strobe
  always_comb begin
    cnt_d     = cnt_q;
    trig_d    = trig_q;
    width_d   = width_q;
    timeout_d = timeout_q;
    valid_d   = 1'b0;
    case (state_q)
      S_TRIG_PENDING: begin
        trig_d = 1'b1;
        cnt_d  = 32'd0;
      end
      S_TRIG: begin
        if (trig_done) begin
          trig_d = 1'b0;
          cnt_d  = 32'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_RISE: begin
        if (rise_q) begin
          // The cycle that produced the rise is the first high cycle.
          cnt_d = 32'd1;
        end else if (start_expired) begin
          width_d   = ECHO_MAX_TICKS;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          cnt_d     = 32'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_MEASURE: begin
        if (!echo_lvl) begin
          width_d   = cnt_q;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          cnt_d     = 32'd0;
        end else if (echo_full) begin
          width_d   = ECHO_MAX_TICKS;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          cnt_d     = 32'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_LOW: begin
        // Hold the counter at zero so cooldown starts fresh once echo drops.
        cnt_d = 32'd0;
      end
      S_COOLDOWN: begin
        if (cool_done) begin
          trig_d = 1'b1;
          cnt_d  = 32'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        trig_d = 1'b0;
        cnt_d  = 32'd0;
      end
    endcase
  end

  assign trig        = trig_q;
  assign echo_width  = width_q;
  assign width_valid = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_hcsr04_echo_timer.sv
// Bench for hcsr04_echo_timer with shortened cooldown/timeout/saturation
// values so every scenario fits in a short run.  Stimulus pushes the expected
// result of each measurement; a monitor pops and compares on every strobe.
module tb_hcsr04_echo_timer;

  localparam logic [31:0] P_TRIG  = 32'd120;
  localparam logic [31:0] P_START = 32'd600;
  localparam logic [31:0] P_EMAX  = 32'd4560;
  localparam logic [31:0] P_COOL  = 32'd720;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        echo = 1'b0;
  logic        trig;
  logic [31:0] echo_width;
  logic        width_valid;
  logic        timeout;

  hcsr04_echo_timer #(
    .TRIG_TICKS(P_TRIG),
    .START_TIMEOUT_TICKS(P_START),
    .ECHO_MAX_TICKS(P_EMAX),
    .COOLDOWN_TICKS(P_COOL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .echo(echo),
    .trig(trig),
    .echo_width(echo_width),
    .width_valid(width_valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] width;
    logic        tmo;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_tests = 0;
  int     n_fail = 0;
  int     n_valid = 0;
  int     n_pushed = 0;
  int     n_unheld = 0;
  longint cyc = 0;
  longint last_valid_cyc = 0;
  longint trig_rise_cyc = 0;
  logic   mon_en = 1'b0;
  logic   rst_seen = 1'b0;
  logic   prev_valid = 1'b0;
  logic   prev_trig = 1'b0;
  logic   prev_tmo = 1'b0;
  logic [31:0] prev_w = 32'd0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset_n;
  end

  task automatic check(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic check_range(input string name, input longint act,
                             input longint lo, input longint hi);
    n_tests++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end else begin
      $display("[TB] ok %s = %0d", name, act);
    end
  endtask

  task automatic push_exp(input logic [31:0] w, input logic t);
    exp_q.push_back('{width: w, tmo: t});
    n_pushed++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_trig(input logic lvl, input int max, output longint at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (trig !== lvl && n < max);
    check("trig_level_reached", (trig === lvl), 1);
    at = cyc;
  endtask

  task automatic wait_valid(input int max, output longint at);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (width_valid !== 1'b1 && n < max);
    check("strobe_reached", (width_valid === 1'b1), 1);
    at = cyc;
  endtask

  // Monitor: scoreboard on each strobe, trigger length, held-output tracking
  always @(negedge clk) begin
    if (mon_en) begin
      if (width_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        check("strobe_not_adjacent", prev_valid, 0);
        check("strobe_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("echo_width", echo_width, mon_e.width);
          check("timeout", timeout, mon_e.tmo);
        end
      end else if (rst_seen && (echo_width !== prev_w || timeout !== prev_tmo)) begin
        n_unheld++;
      end
      if (trig && !prev_trig) begin
        trig_rise_cyc = cyc;
      end
      if (!trig && prev_trig && rst_seen) begin
        check("trig_high_cycles", cyc - trig_rise_cyc, P_TRIG);
      end
    end
    prev_valid = width_valid;
    prev_trig  = trig;
    prev_w     = echo_width;
    prev_tmo   = timeout;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint t_f;
    longint t_v;
    longint t_r;
    longint t_e;
    longint t_e2;
    int     v0;

    // 1. Reset with echo toggling, then first trigger
    repeat (5) begin
      @(posedge clk);
      #1 echo = ~echo;
    end
    @(negedge clk);
    check("rst_trig", trig, 0);
    check("rst_echo_width", echo_width, 0);
    check("rst_width_valid", width_valid, 0);
    check("rst_timeout", timeout, 0);
    echo    = 1'b0;
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);
    check("trig_on_first_edge", trig, 1);

    // 2. Normal echo, then cooldown measured from the strobe
    wait_trig(1'b0, 200, t_f);
    tick(50);
    push_exp(32'd800, 1'b0);
    echo = 1'b1;
    tick(800);
    echo = 1'b0;
    wait_valid(50, t_v);
    wait_trig(1'b1, P_COOL + 50, t_r);
    check("cooldown_after_strobe", t_r - t_v, P_COOL);

    // 3. No echo -> saturated timeout result, then a good echo
    wait_trig(1'b0, P_TRIG + 10, t_f);
    push_exp(P_EMAX, 1'b1);
    wait_valid(P_START + 20, t_v);
    check("no_echo_latency", t_v - t_f, P_START);
    wait_trig(1'b1, P_COOL + 50, t_r);
    wait_trig(1'b0, P_TRIG + 10, t_f);
    tick(20);
    push_exp(32'd300, 1'b0);
    echo = 1'b1;
    tick(300);
    echo = 1'b0;
    wait_valid(50, t_v);

    // 4. Overrun: single strobe at saturation, cooldown from echo fall
    wait_trig(1'b1, P_COOL + 50, t_r);
    wait_trig(1'b0, P_TRIG + 10, t_f);
    tick(10);
    push_exp(P_EMAX, 1'b1);
    v0   = n_valid;
    echo = 1'b1;
    t_e  = cyc;
    tick(5000);
    echo = 1'b0;
    t_e2 = cyc;
    check("overrun_strobe_count", n_valid - v0, 1);
    check_range("overrun_strobe_time", last_valid_cyc - t_e, P_EMAX, P_EMAX + 6);
    wait_trig(1'b1, P_COOL + 50, t_r);
    check_range("overrun_cooldown_from_fall", t_r - t_e2, P_COOL, P_COOL + 6);

    // 5. Echo pulses during trig-high and cooldown are ignored
    tick(2);
    echo = 1'b1;
    tick(10);
    echo = 1'b0;
    tick(3);
    echo = 1'b1;
    tick(100);
    echo = 1'b0;
    wait_trig(1'b0, P_TRIG + 10, t_f);
    tick(40);
    push_exp(32'd200, 1'b0);
    echo = 1'b1;
    tick(200);
    echo = 1'b0;
    wait_valid(50, t_v);
    tick(100);
    echo = 1'b1;
    tick(10);
    echo = 1'b0;
    tick(100);
    echo = 1'b1;
    tick(100);
    echo = 1'b0;
    tick(50);
    check("width_held_in_cooldown", echo_width, 200);
    check("timeout_held_in_cooldown", timeout, 0);
    // Echo already high when the wait for a rise begins
    wait_trig(1'b1, P_COOL + 50, t_r);
    tick(50);
    echo = 1'b1;
    wait_trig(1'b0, P_TRIG + 10, t_f);
    tick(200);
    echo = 1'b0;
    tick(200);
    push_exp(32'd1000, 1'b0);
    echo = 1'b1;
    tick(1000);
    echo = 1'b0;
    wait_valid(50, t_v);

    // 6. Reset in the middle of a measurement
    wait_trig(1'b1, P_COOL + 50, t_r);
    wait_trig(1'b0, P_TRIG + 10, t_f);
    tick(30);
    echo = 1'b1;
    tick(4000);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_trig", trig, 0);
    check("midrst_echo_width", echo_width, 0);
    check("midrst_width_valid", width_valid, 0);
    check("midrst_timeout", timeout, 0);
    reset_n = 1'b1;
    echo    = 1'b0;
    wait_trig(1'b1, 3, t_r);
    wait_trig(1'b0, P_TRIG + 10, t_f);
    tick(25);
    push_exp(32'd500, 1'b0);
    echo = 1'b1;
    tick(500);
    echo = 1'b0;
    wait_valid(50, t_v);
    tick(20);

    check("queue_drained", exp_q.size(), 0);
    check("strobe_count", n_valid, n_pushed);
    check("outputs_held_between_strobes", n_unheld, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
